// File: rtl/tx_frame_arb_pkg.sv
// Shared types for the MAC transmit FIFO frame arbiter.
// State encoding and the word layout of the 32-bit sop/eop/mod interface.
package tx_frame_arb_pkg;

  localparam int DATA_W = 32;
  localparam int MOD_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
  } tx_word_t;

endpackage

// File: rtl/tx_frame_arb.sv
// Two-source, frame-locked round-robin arbiter in front of the MAC TX FIFO.
// Combinational pass-through while busy; idle gap after every frame.
module tx_frame_arb
  import tx_frame_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_s0_data,
  input  logic              i_s0_vld,
  input  logic              i_s0_sop,
  input  logic              i_s0_eop,
  input  logic [MOD_W-1:0]  i_s0_mod,
  output logic              o_s0_rdy,
  input  logic [DATA_W-1:0] i_s1_data,
  input  logic              i_s1_vld,
  input  logic              i_s1_sop,
  input  logic              i_s1_eop,
  input  logic [MOD_W-1:0]  i_s1_mod,
  output logic              o_s1_rdy,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_vld,
  output logic              o_tx_sop,
  output logic              o_tx_eop,
  output logic [MOD_W-1:0]  o_tx_mod,
  input  logic              i_tx_rdy,
  output logic              o_busy,
  output logic              o_owner,
  output logic [CNT_W-1:0]  o_frm_cnt0,
  output logic [CNT_W-1:0]  o_frm_cnt1,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum;

  tx_word_t w0, w1, sel_w;
  logic     sel_vld;
  logic     req0, req1;
  logic     drop0, drop1;
  logic     fire_eop;

  assign w0 = {i_s0_data, i_s0_sop, i_s0_eop, i_s0_mod};
  assign w1 = {i_s1_data, i_s1_sop, i_s1_eop, i_s1_mod};

  assign sel_w   = owner_q ? w1 : w0;
  assign sel_vld = owner_q ? i_s1_vld : i_s0_vld;

  assign req0 = i_s0_vld & i_s0_sop;
  assign req1 = i_s1_vld & i_s1_sop;

  assign fire_eop = (state_q == ST_BUSY) & sel_vld
                  & i_tx_rdy & sel_w.eop;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gap_d     = gap_q;
    drop0     = 1'b0;
    drop1     = 1'b0;
    o_s0_rdy  = 1'b0;
    o_s1_rdy  = 1'b0;
    o_tx_vld  = 1'b0;
    o_tx_data = '0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_tx_mod  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // stray mid-frame words are flushed so a source can resync
        drop0    = i_s0_vld & ~i_s0_sop;
        drop1    = i_s1_vld & ~i_s1_sop;
        o_s0_rdy = drop0;
        o_s1_rdy = drop1;
        if (req0 | req1) begin
          state_d = ST_BUSY;
          owner_d = (req0 & req1) ? ~last_q : req1;
        end
      end
      ST_BUSY: begin
        o_tx_vld  = sel_vld;
        o_tx_data = sel_w.data;
        o_tx_sop  = sel_w.sop;
        o_tx_eop  = sel_w.eop;
        o_tx_mod  = sel_w.mod;
        if (owner_q) o_s1_rdy = i_tx_rdy;
        else         o_s0_rdy = i_tx_rdy;
        if (fire_eop) begin
          last_d = owner_q;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_q}
                  + (CNT_W+1)'(drop0)
                  + (CNT_W+1)'(drop1);
  assign drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
      if (fire_eop & ~owner_q) cnt0_q <= cnt0_q + CNT_W'(1);
      if (fire_eop &  owner_q) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign o_busy     = (state_q == ST_BUSY);
  assign o_owner    = owner_q;
  assign o_frm_cnt0 = cnt0_q;
  assign o_frm_cnt1 = cnt1_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_tx_frame_arb.sv
// Scoreboard bench for tx_frame_arb: source BFMs feed queued frames,
// a monitor pops expected words as the MAC side accepts them.
module tb_tx_frame_arb;
  import tx_frame_arb_pkg::*;

  localparam int CNT_W = 16;
  localparam int GAP   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s0_data, s1_data, tx_data;
  logic s0_vld, s0_sop, s0_eop, s0_rdy;
  logic s1_vld, s1_sop, s1_eop, s1_rdy;
  logic [1:0] s0_mod, s1_mod, tx_mod;
  logic tx_vld, tx_sop, tx_eop, tx_rdy;
  logic busy, owner;
  logic [CNT_W-1:0] frm_cnt0, frm_cnt1, drop_cnt;

  logic [31:0] z_s0_data, z_s1_data, z_tx_data;
  logic z_s0_vld, z_s0_sop, z_s0_eop, z_s0_rdy;
  logic z_s1_vld, z_s1_sop, z_s1_eop, z_s1_rdy;
  logic [1:0] z_s0_mod, z_s1_mod, z_tx_mod;
  logic z_tx_vld, z_tx_sop, z_tx_eop, z_tx_rdy;
  logic z_busy, z_owner;
  logic [CNT_W-1:0] z_cnt0, z_cnt1, z_drop;

  tx_frame_arb #(.GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s0_data(s0_data), .i_s0_vld(s0_vld), .i_s0_sop(s0_sop),
    .i_s0_eop(s0_eop), .i_s0_mod(s0_mod), .o_s0_rdy(s0_rdy),
    .i_s1_data(s1_data), .i_s1_vld(s1_vld), .i_s1_sop(s1_sop),
    .i_s1_eop(s1_eop), .i_s1_mod(s1_mod), .o_s1_rdy(s1_rdy),
    .o_tx_data(tx_data), .o_tx_vld(tx_vld), .o_tx_sop(tx_sop),
    .o_tx_eop(tx_eop), .o_tx_mod(tx_mod), .i_tx_rdy(tx_rdy),
    .o_busy(busy), .o_owner(owner),
    .o_frm_cnt0(frm_cnt0), .o_frm_cnt1(frm_cnt1),
    .o_drop_cnt(drop_cnt)
  );

  tx_frame_arb #(.GAP_CYCLES(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_s0_data(z_s0_data), .i_s0_vld(z_s0_vld), .i_s0_sop(z_s0_sop),
    .i_s0_eop(z_s0_eop), .i_s0_mod(z_s0_mod), .o_s0_rdy(z_s0_rdy),
    .i_s1_data(z_s1_data), .i_s1_vld(z_s1_vld), .i_s1_sop(z_s1_sop),
    .i_s1_eop(z_s1_eop), .i_s1_mod(z_s1_mod), .o_s1_rdy(z_s1_rdy),
    .o_tx_data(z_tx_data), .o_tx_vld(z_tx_vld), .o_tx_sop(z_tx_sop),
    .o_tx_eop(z_tx_eop), .o_tx_mod(z_tx_mod), .i_tx_rdy(z_tx_rdy),
    .o_busy(z_busy), .o_owner(z_owner),
    .o_frm_cnt0(z_cnt0), .o_frm_cnt1(z_cnt1),
    .o_drop_cnt(z_drop)
  );

  tx_word_t q0[$], q1[$], exp_q[$], zexp[$];
  int sop_cyc[$], eop_cyc[$], pres0[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_seen = 0;
  bit tog = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    tx_rdy = tog ? cyc[0] : 1'b1;
  end

  initial begin
    bit fire;
    bit seen;
    fire = 1'b0;
    seen = 1'b0;
    {s0_data, s0_sop, s0_eop, s0_mod} = '0;
    s0_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete();
        seen = 1'b0;
      end else if (fire && q0.size() > 0) begin
        void'(q0.pop_front());
        seen = 1'b0;
      end
      if (rst_n && q0.size() > 0) begin
        {s0_data, s0_sop, s0_eop, s0_mod} = q0[0];
        s0_vld = 1'b1;
      end else begin
        {s0_data, s0_sop, s0_eop, s0_mod} = '0;
        s0_vld = 1'b0;
      end
      #4;
      fire = s0_vld & s0_rdy;
      if (s0_vld && s0_sop && !seen) begin
        pres0.push_back(cyc);
        seen = 1'b1;
      end
    end
  end

  initial begin
    bit fire;
    fire = 1'b0;
    {s1_data, s1_sop, s1_eop, s1_mod} = '0;
    s1_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) q1.delete();
      else if (fire && q1.size() > 0) void'(q1.pop_front());
      if (rst_n && q1.size() > 0) begin
        {s1_data, s1_sop, s1_eop, s1_mod} = q1[0];
        s1_vld = 1'b1;
      end else begin
        {s1_data, s1_sop, s1_eop, s1_mod} = '0;
        s1_vld = 1'b0;
      end
      #4;
      fire = s1_vld & s1_rdy;
    end
  end

  initial begin
    tx_word_t e;
    forever begin
      @(negedge clk);
      #4;
      if (tx_vld) vld_seen = vld_seen + 1;
      if (tx_vld && tx_rdy) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL scoreboard_extra got %h", tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({tx_data, tx_sop, tx_eop, tx_mod} !== e) begin
            errors = errors + 1;
            $display("FAIL scoreboard got %h/%b%b/%0d exp %h/%b%b/%0d",
              tx_data, tx_sop, tx_eop, tx_mod,
              e.data, e.sop, e.eop, e.mod);
          end
        end
        if (tx_sop) sop_cyc.push_back(cyc);
        if (tx_eop) eop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic tx_word_t mk(input logic [7:0] tag, input int i,
                                  input int n, input logic [1:0] m);
    tx_word_t w;
    w.data = {8'hC5, tag, 16'(i)};
    w.sop  = (i == 0);
    w.eop  = (i == n - 1);
    w.mod  = w.eop ? m : 2'd0;
    return w;
  endfunction

  task automatic frame(input int src, input logic [7:0] tag,
                       input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      if (src == 1) q1.push_back(mk(tag, i, n, m));
      else          q0.push_back(mk(tag, i, n, m));
    end
  endtask

  task automatic expect_frame(input logic [7:0] tag, input int n,
                              input logic [1:0] m);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(tag, i, n, m));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (n >= budget) begin
      errors = errors + 1;
      $display("FAIL drain_timeout left %0d exp 0", exp_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    checks = checks + 4;
    if (busy !== 1'b0 || owner !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_state busy=%b owner=%b exp 0 0", busy, owner);
    end
    if (tx_vld !== 1'b0 || tx_data !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL reset_tx vld=%b data=%h exp 0", tx_vld, tx_data);
    end
    if (frm_cnt0 !== '0 || frm_cnt1 !== '0 || drop_cnt !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_cnt %0d %0d %0d exp 0", frm_cnt0, frm_cnt1,
               drop_cnt);
    end
    if (s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_rdy %b %b exp 0 0", s0_rdy, s1_rdy);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_source();
    @(negedge clk);
    #1;
    sop_cyc.delete();
    eop_cyc.delete();
    pres0.delete();
    frame(0, 8'h01, 4, 2'd1);
    frame(0, 8'h02, 2, 2'd2);
    expect_frame(8'h01, 4, 2'd1);
    expect_frame(8'h02, 2, 2'd2);
    wait_drain(200);
    checks = checks + 1;
    if (sop_cyc.size() != 2 || eop_cyc.size() != 2 || pres0.size() < 1) begin
      errors = errors + 1;
      $display("FAIL single_frames sops %0d eops %0d exp 2 2",
               sop_cyc.size(), eop_cyc.size());
    end else begin
      checks = checks + 3;
      if (sop_cyc[0] != pres0[0] + 1) begin
        errors = errors + 1;
        $display("FAIL grant_latency got %0d exp 1", sop_cyc[0] - pres0[0]);
      end
      if (eop_cyc[0] != sop_cyc[0] + 3) begin
        errors = errors + 1;
        $display("FAIL burst_len got %0d exp 3", eop_cyc[0] - sop_cyc[0]);
      end
      if (sop_cyc[1] != eop_cyc[0] + GAP + 2) begin
        errors = errors + 1;
        $display("FAIL gap_spacing got %0d exp %0d",
                 sop_cyc[1] - eop_cyc[0], GAP + 2);
      end
    end
    checks = checks + 1;
    if (frm_cnt0 !== 16'd2 || frm_cnt1 !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL single_cnt got %0d/%0d exp 2/0", frm_cnt0, frm_cnt1);
    end
  endtask

  task automatic test_alternate();
    pulse_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      frame(0, 8'h10 + 8'(2 * k), 2 + k, 2'(k));
      frame(1, 8'h11 + 8'(2 * k), 3 - k, 2'(k + 1));
    end
    for (int k = 0; k < 3; k++) begin
      expect_frame(8'h10 + 8'(2 * k), 2 + k, 2'(k));
      expect_frame(8'h11 + 8'(2 * k), 3 - k, 2'(k + 1));
    end
    wait_drain(400);
    checks = checks + 2;
    if (frm_cnt0 !== 16'd3 || frm_cnt1 !== 16'd3) begin
      errors = errors + 1;
      $display("FAIL alt_cnt got %0d/%0d exp 3/3", frm_cnt0, frm_cnt1);
    end
    if (owner !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL alt_owner got %b exp 1", owner);
    end
  endtask

  task automatic test_back_pressure();
    int n;
    int hi;
    int lo;
    n = 0;
    hi = 0;
    lo = 0;
    @(negedge clk);
    #1;
    tog = 1'b1;
    frame(0, 8'h20, 5, 2'd3);
    frame(1, 8'h21, 3, 2'd0);
    expect_frame(8'h20, 5, 2'd3);
    expect_frame(8'h21, 3, 2'd0);
    while (q0.size() != 0 && n < 100) begin
      @(negedge clk);
      #4;
      n++;
      if (tx_vld && q0.size() != 0) begin
        checks = checks + 1;
        if (s0_rdy !== tx_rdy || s1_rdy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL rdy_mirror s0=%b s1=%b exp %b 0",
                   s0_rdy, s1_rdy, tx_rdy);
        end
        if (tx_rdy) hi++;
        else        lo++;
      end
    end
    checks = checks + 1;
    if (hi < 5 || lo < 1) begin
      errors = errors + 1;
      $display("FAIL bp_coverage hi %0d lo %0d exp >=5 >=1", hi, lo);
    end
    wait_drain(200);
    tog = 1'b0;
    checks = checks + 1;
    if (frm_cnt0 !== 16'd4 || frm_cnt1 !== 16'd4) begin
      errors = errors + 1;
      $display("FAIL bp_cnt got %0d/%0d exp 4/4", frm_cnt0, frm_cnt1);
    end
  endtask

  task automatic test_drop();
    int v0;
    @(negedge clk);
    #1;
    v0 = vld_seen;
    for (int i = 0; i < 5; i++) q1.push_back(mk(8'h40, i + 1, 99, 2'd0));
    wait_drain(30);
    checks = checks + 2;
    if (drop_cnt !== 16'd5) begin
      errors = errors + 1;
      $display("FAIL drop_cnt got %0d exp 5", drop_cnt);
    end
    if (vld_seen != v0) begin
      errors = errors + 1;
      $display("FAIL drop_txvld got %0d exp 0", vld_seen - v0);
    end
  endtask

  task automatic test_single_word();
    tx_word_t e;
    z_tx_rdy = 1'b1;
    @(negedge clk);
    {z_s0_data, z_s0_sop, z_s0_eop, z_s0_mod} = {32'hABCD0001, 1'b1, 1'b1, 2'd3};
    z_s0_vld = 1'b1;
    zexp.push_back({32'hABCD0001, 1'b1, 1'b1, 2'd3});
    #4;
    checks = checks + 1;
    if (z_tx_vld !== 1'b0 || z_s0_rdy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sw_grant vld=%b rdy=%b exp 0 0", z_tx_vld, z_s0_rdy);
    end
    @(negedge clk);
    #4;
    checks = checks + 1;
    e = zexp.pop_front();
    if (z_tx_vld !== 1'b1 || z_s0_rdy !== 1'b1 ||
        {z_tx_data, z_tx_sop, z_tx_eop, z_tx_mod} !== e) begin
      errors = errors + 1;
      $display("FAIL sw_word vld=%b mod=%0d data=%h exp 1 3 %h",
               z_tx_vld, z_tx_mod, z_tx_data, e.data);
    end
    @(negedge clk);
    {z_s0_data, z_s0_sop, z_s0_eop, z_s0_mod} = {32'hABCD0002, 1'b1, 1'b1, 2'd1};
    zexp.push_back({32'hABCD0002, 1'b1, 1'b1, 2'd1});
    #4;
    checks = checks + 1;
    if (z_cnt0 !== 16'd1 || z_busy !== 1'b0 || z_tx_vld !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sw_nogap cnt=%0d busy=%b vld=%b exp 1 0 0",
               z_cnt0, z_busy, z_tx_vld);
    end
    @(negedge clk);
    #4;
    checks = checks + 1;
    e = zexp.pop_front();
    if (z_tx_vld !== 1'b1 ||
        {z_tx_data, z_tx_sop, z_tx_eop, z_tx_mod} !== e) begin
      errors = errors + 1;
      $display("FAIL sw_next vld=%b data=%h exp 1 %h", z_tx_vld, z_tx_data,
               e.data);
    end
    @(negedge clk);
    z_s0_vld = 1'b0;
    #4;
    checks = checks + 1;
    if (z_cnt0 !== 16'd2) begin
      errors = errors + 1;
      $display("FAIL sw_cnt got %0d exp 2", z_cnt0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    sop_cyc.delete();
    frame(0, 8'h30, 6, 2'd2);
    expect_frame(8'h30, 6, 2'd2);
    while (sop_cyc.size() == 0 && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    checks = checks + 1;
    if (sop_cyc.size() == 0) begin
      errors = errors + 1;
      $display("FAIL rst_frame_start got none exp sop");
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 2;
    if (tx_vld !== 1'b0 || busy !== 1'b0 || tx_data !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL rst_async vld=%b busy=%b data=%h exp 0 0 0",
               tx_vld, busy, tx_data);
    end
    if (frm_cnt0 !== '0 || drop_cnt !== '0) begin
      errors = errors + 1;
      $display("FAIL rst_async_cnt %0d %0d exp 0 0", frm_cnt0, drop_cnt);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #4;
    checks = checks + 1;
    if (busy !== 1'b0 || frm_cnt0 !== '0 || frm_cnt1 !== '0 ||
        drop_cnt !== '0) begin
      errors = errors + 1;
      $display("FAIL rst_release busy=%b cnt %0d %0d %0d exp 0",
               busy, frm_cnt0, frm_cnt1, drop_cnt);
    end
    @(negedge clk);
    #1;
    frame(0, 8'h31, 3, 2'd1);
    expect_frame(8'h31, 3, 2'd1);
    wait_drain(100);
    checks = checks + 1;
    if (frm_cnt0 !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL rst_fresh_cnt got %0d exp 1", frm_cnt0);
    end
  endtask

  initial begin
    tx_rdy = 1'b1;
    z_tx_rdy = 1'b1;
    {z_s0_data, z_s0_sop, z_s0_eop, z_s0_mod} = '0;
    {z_s1_data, z_s1_sop, z_s1_eop, z_s1_mod} = '0;
    z_s0_vld = 1'b0;
    z_s1_vld = 1'b0;
    test_reset();
    test_single_source();
    test_alternate();
    test_back_pressure();
    test_drop();
    test_single_word();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
